period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Measures the period and high time of a slow, asynchronous square wave, counted in cycles of the fast system clock.
- Typical inputs are a divided clock or an external test signal.
- This is the receiving end of our divided-clock outputs: it turns a toggling signal back into cycle counts.
- Results feed a display or debug path as a one-cycle valid strobe, plus a timeout/stalled indication.

Parameters:
- CNT_W, 25, width of the period/high-time counters and outputs.
- TIMEOUT, 30000000, number of cycles without a rising edge before a timeout is declared. Must be less than 2^CNT_W.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sig_in  input  1  asynchronous square wave to measure.
- period_out  output  CNT_W  last measured period in clk cycles (rising edge to rising edge).
- high_out  output  CNT_W  cycles sig_in was high within that period.
- period_valid  output  1  one-cycle strobe; period_out and high_out were updated this cycle.
- timeout  output  1  one-cycle strobe; TIMEOUT elapsed with no rising edge.
- stalled  output  1  level; high from a timeout until the next rising edge.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high; it has priority over everything else.
- Reset values: all outputs 0, synchronizer flops 0, cnt and high_cnt 0, state ARM.
- Input path:
  - sig_in passes through two flops (s1, s2), then a history flop s3.
  - rise = s2 & ~s3 (combinational).
  - No glitch filtering.
- Latency: sig_in rises before clk edge k; period_valid is high in the cycle following edge k+2.
- State ARM (after reset, waiting for the first edge):
  - cnt and high_cnt held at 0.
  - On rise: cnt<=1, high_cnt<=1, go to MEAS. No valid strobe.
- State MEAS:
  - Every cycle: cnt<=cnt+1; high_cnt<=high_cnt+s2.
  - On rise: period_out<=cnt, high_out<=high_cnt, period_valid<=1, cnt<=1, high_cnt<=1; stay in MEAS.
  - If cnt==TIMEOUT and no rise: timeout<=1, stalled<=1, go to STALL. period_out and high_out keep their old values.
  - rise and cnt==TIMEOUT in the same cycle: rise wins. Report period TIMEOUT, no timeout strobe.
- State STALL:
  - Counters held at 0.
  - On rise: stalled<=0, cnt<=1, high_cnt<=1, go to MEAS. No valid strobe; the partial interval is discarded.
- Strobe rules: period_valid and timeout default to 0 every cycle and are never both high.
- Counter width: cnt never exceeds TIMEOUT, so there is no wrap. high_cnt <= cnt always.
- Constant sig_in (stuck high or stuck low): timeout fires TIMEOUT cycles after the last rise, then stalled stays high indefinitely.
- Reset mid-measurement: all state cleared, no strobe. The first rise after reset only arms the block.
- Period semantics: for a sig_in period of P cycles, period_out=P and high_out is the high-time count. Both are exact for a stable input; a synchronizer jitter of ±1 cycle is acceptable for a truly asynchronous input.

Decomposition:
- Shared package:
  - state enum (ARM, MEAS, STALL).
  - default CNT_W and TIMEOUT constants.
  - These are shared with the clock-divider constants so that divider and meter defaults agree. A divide-by-10,000,000 toggle gives a period of 20,000,000 cycles, which must be less than TIMEOUT.
- One sub-module, sync_rise:
  - 2-flop synchronizer plus history flop.
  - Outputs s2 (level) and rise.
  - Reusable for buttons and other asynchronous inputs.
- The FSM, counters and output registers stay in period_meter.

Test Plan:
- Square wave, 10 high / 10 low, TIMEOUT=50 → first rise gives no strobe. From the second rise on: period_valid every 20 cycles, period_out=20, high_out=10, timeout never asserts.
- Duty 3 high / 7 low → period_out=10, high_out=3 on every strobe. Change to 6/4 mid-stream → the next full period reports 10 and 6 exactly.
- TIMEOUT=50, hold sig_in low after a measured period → timeout pulses exactly once, 50 cycles after the last rise (counting its cnt=1 cycle). stalled rises with it; period_out keeps 20.
- From STALL: a rise clears stalled with no period_valid. The next 20-cycle period gives period_valid with period_out=20.
- Period exactly equal to TIMEOUT (50) → period_valid with period_out=50, timeout stays 0.
- Assert reset for 1 cycle mid-period → all outputs 0, state ARM. The next rise gives no strobe; the rise after that reports the correct period.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared constants and types for the period meter.
// The defaults sit next to the clock-divider constants so that the divider
// and the meter agree.
package period_meter_pkg;

    // Counter and output width for measured periods and high times.
    localparam int DEF_CNT_W = 25;

    // Cycles without a rising edge before the input is declared stalled.
    localparam int DEF_TIMEOUT = 30_000_000;

    // Divide ratio of the matching clock divider. It toggles its output once
    // per DEF_DIV cycles, so one full output period is twice that.
    localparam int DEF_DIV        = 10_000_000;
    localparam int DEF_DIV_PERIOD = 2 * DEF_DIV;

    // The longest period we expect from the divider must still be measured.
    // It must not trigger the timeout.
    localparam bit DEF_DIV_FITS = (DEF_DIV_PERIOD < DEF_TIMEOUT);

    // ARM   : after reset, waiting for the first rising edge.
    // MEAS  : counting between rising edges.
    // STALL : timed out, waiting for the input to come back.
    typedef enum logic [1:0] {
        ARM   = 2'd0,
        MEAS  = 2'd1,
        STALL = 2'd2
    } meter_state_t;

    // True when a timeout value can be held by a counter of the given width.
    function automatic bit timeout_fits(input int cnt_w, input int timeout);
        longint limit;
        limit = longint'(1) << cnt_w;
        return (timeout > 0) && (longint'(timeout) < limit);
    endfunction

endpackage

// File: rtl/period_meter_sync_rise.sv
// Two-flop synchronizer with a history flop for an asynchronous input.
// It gives the synchronized level and a one-cycle rising-edge pulse.
// Nothing here is specific to the meter, so buttons and other asynchronous
// inputs can reuse it.
module sync_rise (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic s2,
    output logic rise
);

    logic s1;
    logic s3;

    // Shift the raw input through the metastability flops and the history flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/period_meter.sv
// Measures the period and high time of a slow asynchronous square wave.
// Both values are counted in clk cycles.
// Results come out with a one-cycle valid strobe. A missing input is reported
// with a timeout strobe and a stalled level.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             period_valid,
    output logic             timeout,
    output logic             stalled
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);
    localparam bit               TIMEOUT_OK  = timeout_fits(CNT_W, TIMEOUT);

    logic             level;
    logic             rise;

    meter_state_t     state;
    meter_state_t     state_next;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] high_cnt_next;
    logic [CNT_W-1:0] period_next;
    logic [CNT_W-1:0] high_next;
    logic             valid_next;
    logic             timeout_next;
    logic             stalled_next;
    logic             at_limit;

    sync_rise u_sync (
        .clk   (clk),
        .reset (reset),
        .sig   (sig_in),
        .s2    (level),
        .rise  (rise)
    );

    // The timeout compare only works if TIMEOUT fits the counter. An invalid
    // parameter set can never reach the limit, so the timeout never fires.
    assign at_limit = TIMEOUT_OK && (cnt == TIMEOUT_CNT);

    // Hold the FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARM;
        end else begin
            state <= state_next;
        end
    end

    // Work out the next state, counters and result registers.
    // The interval that starts on a rise includes the rise cycle itself.
    // That cycle is high by definition, so both counters restart at 1.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        high_cnt_next = high_cnt;
        period_next   = period_out;
        high_next     = high_out;
        valid_next    = 1'b0;
        timeout_next  = 1'b0;
        stalled_next  = stalled;

        case (state)
            ARM: begin
                cnt_next      = '0;
                high_cnt_next = '0;
                if (rise) begin
                    cnt_next      = ONE_CNT;
                    high_cnt_next = ONE_CNT;
                    state_next    = MEAS;
                end
            end

            MEAS: begin
                // A rise in the same cycle as the limit is a valid period of
                // exactly TIMEOUT. It takes priority over the timeout.
                if (rise) begin
                    period_next   = cnt;
                    high_next     = high_cnt;
                    valid_next    = 1'b1;
                    cnt_next      = ONE_CNT;
                    high_cnt_next = ONE_CNT;
                end else if (at_limit) begin
                    timeout_next  = 1'b1;
                    stalled_next  = 1'b1;
                    cnt_next      = '0;
                    high_cnt_next = '0;
                    state_next    = STALL;
                end else begin
                    cnt_next      = cnt + ONE_CNT;
                    high_cnt_next = high_cnt + CNT_W'(level);
                end
            end

            STALL: begin
                // The partial interval that ends the stall is thrown away.
                // Only the next full period is reported.
                cnt_next      = '0;
                high_cnt_next = '0;
                if (rise) begin
                    stalled_next  = 1'b0;
                    cnt_next      = ONE_CNT;
                    high_cnt_next = ONE_CNT;
                    state_next    = MEAS;
                end
            end

            default: begin
                cnt_next      = '0;
                high_cnt_next = '0;
                state_next    = ARM;
            end
        endcase
    end

    // Register counters, results and strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            high_cnt     <= '0;
            period_out   <= '0;
            high_out     <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            high_cnt     <= high_cnt_next;
            period_out   <= period_next;
            high_out     <= high_next;
            period_valid <= valid_next;
            timeout      <= timeout_next;
            stalled      <= stalled_next;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter.
// The stimulus process drives sig_in one clock at a time and feeds each
// sample to a timestamp-level reference model. The model pushes the expected
// strobes into a queue. A separate monitor pops and compares them whenever
// the DUT strobes.
module tb_period_meter;

    localparam int CNT_W   = 25;
    localparam int TIMEOUT = 50;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             period_valid;
    logic             timeout;
    logic             stalled;

    typedef struct {
        int due;
        bit is_timeout;
        int period;
        int high;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int   idx = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    // Reference model state.
    // mode: 0 = not measuring, 1 = measuring, 2 = stalled.
    int   mode = 0;
    bit   dline[$];
    bit   window[$];
    bit   prev_lvl = 1'b0;
    int   exp_period = 0;
    int   exp_high = 0;
    bit   exp_stalled = 1'b0;

    period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sig_in       (sig_in),
        .period_out   (period_out),
        .high_out     (high_out),
        .period_valid (period_valid),
        .timeout      (timeout),
        .stalled      (stalled)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d cycle=%0d", name, actual, expected, idx);
        end
    endtask

    // Advance the model by one clock edge.
    // A sample reaches the measuring logic two edges after it is captured.
    // The delay line holds samples in flight. Reset empties it, because
    // reset flushes the synchronizer.
    task automatic modelStep(input bit v, input bit rst);
        bit lvl;
        bit rise;
        int ones;
        exp_t e;
        if (rst) begin
            mode        = 0;
            dline.delete();
            window.delete();
            prev_lvl    = 1'b0;
            exp_period  = 0;
            exp_high    = 0;
            exp_stalled = 1'b0;
            sb.delete();
            mon_en      = 1'b1;
            return;
        end
        dline.push_back(v);
        if (dline.size() < 3) return;
        lvl      = dline.pop_front();
        rise     = lvl && !prev_lvl;
        prev_lvl = lvl;
        if (mode == 1) begin
            if (rise) begin
                ones = 0;
                foreach (window[i]) ones += int'(window[i]);
                e.due        = idx + 1;
                e.is_timeout = 1'b0;
                e.period     = window.size();
                e.high       = ones;
                sb.push_back(e);
                exp_period = e.period;
                exp_high   = e.high;
                window.delete();
                window.push_back(1'b1);
            end else if (window.size() == TIMEOUT) begin
                e.due        = idx + 1;
                e.is_timeout = 1'b1;
                e.period     = 0;
                e.high       = 0;
                sb.push_back(e);
                exp_stalled = 1'b1;
                mode        = 2;
                window.delete();
            end else begin
                window.push_back(lvl);
            end
        end else if (rise) begin
            mode        = 1;
            exp_stalled = 1'b0;
            window.delete();
            window.push_back(1'b1);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit rst);
        reset  = rst;
        sig_in = v;
        @(posedge clk);
        #1;
        modelStep(v, rst);
        idx++;
    endtask

    task automatic squareWave(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            repeat (hi) applyStimulus(1'b1, 1'b0);
            repeat (lo) applyStimulus(1'b0, 1'b0);
        end
    endtask

    // Monitor: compare strobes against the scoreboard and levels against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == idx) begin
                mon_e = sb.pop_front();
                checkOutput("period_valid", int'(period_valid), int'(!mon_e.is_timeout));
                checkOutput("timeout", int'(timeout), int'(mon_e.is_timeout));
            end else begin
                checkOutput("no_strobe", int'({period_valid, timeout}), 0);
            end
            checkOutput("stalled", int'(stalled), int'(exp_stalled));
            checkOutput("period_out", int'(period_out), exp_period);
            checkOutput("high_out", int'(high_out), exp_high);
        end
    end

    // Directed scenarios, then random periods and stuck inputs.
    initial begin
        repeat (3) applyStimulus(1'b0, 1'b1);
        repeat (5) applyStimulus(1'b0, 1'b0);

        squareWave(10, 10, 6);
        squareWave(3, 7, 5);
        squareWave(6, 4, 4);

        repeat (80) applyStimulus(1'b0, 1'b0);
        squareWave(10, 10, 3);

        squareWave(25, 25, 3);
        squareWave(30, 21, 2);
        squareWave(25, 24, 2);

        squareWave(10, 10, 2);
        repeat (7) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0);
        squareWave(10, 10, 3);

        for (int k = 0; k < 60; k++) begin
            squareWave(int'($urandom_range(1, 30)), int'($urandom_range(1, 30)), 1);
            if ($urandom_range(0, 19) == 0) applyStimulus(sig_in, 1'b1);
        end

        repeat (70) applyStimulus(1'b1, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0);

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
